// File: rtl/mv_xbar_pkg.sv
// rtl/mv_xbar_pkg.sv - TL-UL types and host-tag helpers shared by the host arbiter.
package mv_xbar_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;

    // Wide enough for the largest supported host count (8).
    typedef logic [2:0] host_idx_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    function automatic int host_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    // Host index occupies the top w bits of the source id.
    function automatic logic [TL_AIW-1:0] tag_source(input logic [TL_AIW-1:0] src,
                                                     input host_idx_t idx, input int w);
        logic [TL_AIW-1:0] keep;
        keep = {TL_AIW{1'b1}} >> w;
        return (src & keep) | ({{(TL_AIW-3){1'b0}}, idx} << (TL_AIW - w));
    endfunction

    function automatic logic [TL_AIW-1:0] untag_source(input logic [TL_AIW-1:0] src, input int w);
        return src & ({TL_AIW{1'b1}} >> w);
    endfunction

endpackage

// File: rtl/mv_rr_arb.sv
// rtl/mv_rr_arb.sv - Round-robin request arbiter with an external grant lock.
module mv_rr_arb
    import mv_xbar_pkg::*;
#(
    parameter int NumHosts = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumHosts-1:0] req,
    input  logic                lock,
    input  host_idx_t           locked_idx,
    input  logic                advance,
    output logic                gnt_valid,
    output host_idx_t           gnt_idx,
    output logic [NumHosts-1:0] gnt_onehot
);

    host_idx_t           ptr_q;
    logic [NumHosts-1:0] req_rot;
    int unsigned         cand;

    // Scan from the highest offset down so the lowest offset after the pointer wins.
    always_comb begin
        req_rot   = NumHosts'({req, req} >> ptr_q);
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (lock) begin
            gnt_valid = 1'b1;
            gnt_idx   = locked_idx;
        end else begin
            for (int off = NumHosts - 1; off >= 0; off--) begin
                if (req_rot[off]) begin
                    cand = int'(ptr_q) + off;
                    if (cand >= NumHosts) cand = cand - NumHosts;
                    gnt_valid = 1'b1;
                    gnt_idx   = host_idx_t'(cand);
                end
            end
        end
        for (int i = 0; i < NumHosts; i++) begin
            gnt_onehot[i] = gnt_valid && (gnt_idx == host_idx_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (gnt_idx == host_idx_t'(NumHosts - 1)) ? '0 : gnt_idx + 3'd1;
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// rtl/tlul_host_arbiter.sv - N-host to 1-device TL-UL arbiter with source tagging and per-host limits.
module tlul_host_arbiter
    import mv_xbar_pkg::*;
#(
    parameter int  NumHosts       = 2,
    parameter int  MaxOutstanding = 2,
    localparam int HostIdW        = host_id_w(NumHosts),
    localparam int CntW           = cnt_w(MaxOutstanding)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i [NumHosts],
    output tl_d2h_t         tl_h_o [NumHosts],
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic            bad_rsp_o,
    output logic [CntW-1:0] outstanding_o [NumHosts]
);

    logic [NumHosts-1:0] eligible, gnt_onehot, inc, dec;
    logic                gnt_valid, lock_q, a_hs, d_hs, tag_ok;
    host_idx_t           gnt_idx, locked_idx_q, rsp_idx;
    logic [CntW-1:0]     cnt_q [NumHosts];

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            eligible[i] = tl_h_i[i].a_valid && (cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    mv_rr_arb #(.NumHosts(NumHosts)) u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req        (eligible),
        .lock       (lock_q),
        .locked_idx (locked_idx_q),
        .advance    (a_hs),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    assign rsp_idx   = host_idx_t'(tl_d_i.d_source[TL_AIW-1 -: HostIdW]);
    assign tag_ok    = {1'b0, rsp_idx} < 4'(NumHosts);
    assign a_hs      = tl_d_o.a_valid && tl_d_i.a_ready;
    assign d_hs      = tl_d_i.d_valid && tl_d_o.d_ready && tag_ok;
    assign bad_rsp_o = rst_ni && tl_d_i.d_valid && !tag_ok;

    // Responses with an unknown tag are accepted and dropped so the device never stalls on them.
    always_comb begin
        tl_d_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (gnt_onehot[i]) begin
                tl_d_o          = tl_h_i[i];
                tl_d_o.a_source = tag_source(tl_h_i[i].a_source, host_idx_t'(i), HostIdW);
            end
        end
        tl_d_o.a_valid = rst_ni && gnt_valid && tl_d_o.a_valid;
        tl_d_o.d_ready = !tag_ok;
        for (int i = 0; i < NumHosts; i++) begin
            if (tag_ok && rsp_idx == host_idx_t'(i)) tl_d_o.d_ready = tl_h_i[i].d_ready;
        end
    end

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]          = tl_d_i;
            tl_h_o[i].d_source = untag_source(tl_d_i.d_source, HostIdW);
            tl_h_o[i].d_valid  = rst_ni && tl_d_i.d_valid && tag_ok && (rsp_idx == host_idx_t'(i));
            tl_h_o[i].a_ready  = rst_ni && gnt_onehot[i] && tl_d_i.a_ready;
            inc[i]             = a_hs && gnt_onehot[i];
            dec[i]             = d_hs && (rsp_idx == host_idx_t'(i));
            outstanding_o[i]   = cnt_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
        end else begin
            lock_q       <= tl_d_o.a_valid && !tl_d_i.a_ready;
            locked_idx_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumHosts; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumHosts; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_sva
        a_src_clean: assert property (@(posedge clk_i) disable iff (!rst_ni)
            tl_h_i[gi].a_valid |-> tl_h_i[gi].a_source[TL_AIW-1 -: HostIdW] == '0);
        no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (dec[gi] && !inc[gi]) |-> cnt_q[gi] != '0);
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// tb/tb_tlul_host_arbiter.sv - Directed self-checking bench for tlul_host_arbiter (2- and 3-host builds).
module tb_tlul_host_arbiter;
    import mv_xbar_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_h2d_t    h2_i [2];
    tl_d2h_t    h2_o [2];
    tl_h2d_t    dev2_o;
    tl_d2h_t    dev2_i;
    logic       bad2;
    logic [1:0] out2 [2];

    tl_h2d_t    h3_i [3];
    tl_d2h_t    h3_o [3];
    tl_h2d_t    dev3_o;
    tl_d2h_t    dev3_i;
    logic       bad3;
    logic [1:0] out3 [3];

    int n_assert = 0;
    int n_fail = 0;

    tlul_host_arbiter #(.NumHosts(2), .MaxOutstanding(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h2_i), .tl_h_o(h2_o), .tl_d_o(dev2_o),
        .tl_d_i(dev2_i), .bad_rsp_o(bad2), .outstanding_o(out2));

    tlul_host_arbiter #(.NumHosts(3), .MaxOutstanding(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h3_i), .tl_h_o(h3_o), .tl_d_o(dev3_o),
        .tl_d_i(dev3_i), .bad_rsp_o(bad3), .outstanding_o(out3));

    function automatic tl_h2d_t mk_get(input logic [31:0] addr, input logic [7:0] src);
        tl_h2d_t r;
        r = '0;
        r.a_valid = 1'b1; r.a_opcode = Get; r.a_size = 2'd2; r.a_source = src;
        r.a_address = addr; r.a_mask = 4'hF; r.d_ready = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin h2_i[i] = '0; h2_i[i].d_ready = 1'b1; end
        for (int i = 0; i < 3; i++) begin h3_i[i] = '0; h3_i[i].d_ready = 1'b1; end
        dev2_i = '0; dev2_i.a_ready = 1'b1; dev2_i.d_opcode = AccessAckData;
        dev3_i = '0; dev3_i.a_ready = 1'b1; dev3_i.d_opcode = AccessAckData;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    task automatic d2(input logic v, input logic [7:0] src);
        dev2_i.d_valid = v; dev2_i.d_source = src; dev2_i.d_data = {24'hD00D00, src};
    endtask

    task automatic test_reset();
        idle();
        h2_i[0] = mk_get(32'h10, 8'h1);
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dev_avalid: got %0h expected 0", dev2_o.a_valid); end
        n_assert++; if (h2_o[0].a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %0h expected 0", h2_o[0].a_ready); end
        n_assert++; if (h2_o[0].d_valid !== 1'b0 || h2_o[1].d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid: got %0h%0h expected 00", h2_o[0].d_valid, h2_o[1].d_valid); end
        n_assert++; if (bad2 !== 1'b0 || bad3 !== 1'b0) begin n_fail++; $display("FAIL rst_bad: got %0h%0h expected 00", bad2, bad3); end
        n_assert++; if (out2[0] !== 2'd0 || out2[1] !== 2'd0) begin n_fail++; $display("FAIL rst_counts: got %0d %0d expected 0 0", out2[0], out2[1]); end
        step();
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        h2_i[0] = mk_get(32'h100, 8'h03);
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h03) begin n_fail++; $display("FAIL single_req: got v%0h src %0h expected v1 src 3", dev2_o.a_valid, dev2_o.a_source); end
        n_assert++; if (dev2_o.a_address !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %0h expected 100", dev2_o.a_address); end
        n_assert++; if (h2_o[0].a_ready !== 1'b1 || h2_o[1].a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %0h%0h expected 10", h2_o[0].a_ready, h2_o[1].a_ready); end
        step();
        h2_i[0].a_valid = 1'b0;
        h2_i[1].d_ready = 1'b0;
        #1;
        n_assert++; if (out2[0] !== 2'd1) begin n_fail++; $display("FAIL single_cnt_up: got %0d expected 1", out2[0]); end
        d2(1'b1, 8'h03);
        #1;
        n_assert++; if (h2_o[0].d_valid !== 1'b1 || h2_o[0].d_source !== 8'h03 || h2_o[0].d_data !== 32'hD00D0003) begin n_fail++; $display("FAIL single_rsp: got v%0h src %0h data %0h expected v1 src 3 data d00d0003", h2_o[0].d_valid, h2_o[0].d_source, h2_o[0].d_data); end
        n_assert++; if (h2_o[1].d_valid !== 1'b0 || dev2_o.d_ready !== 1'b1) begin n_fail++; $display("FAIL single_route: got h1v %0h dready %0h expected 0 1", h2_o[1].d_valid, dev2_o.d_ready); end
        step();
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (out2[0] !== 2'd0) begin n_fail++; $display("FAIL single_cnt_down: got %0d expected 0", out2[0]); end
    endtask

    task automatic test_alternate();
        int hs0, hs1;
        logic [7:0] exp_src;
        hs0 = 0; hs1 = 0;
        do_reset();
        h2_i[0] = mk_get(32'h200, 8'h00);
        h2_i[1] = mk_get(32'h300, 8'h00);
        for (int k = 0; k < 100; k++) begin
            if (k > 0) d2(1'b1, ((k - 1) % 2 == 1) ? 8'h80 : 8'h00);
            exp_src = (k % 2 == 1) ? 8'h80 : 8'h00;
            #1;
            n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== exp_src) begin n_fail++; $display("FAIL alt_grant[%0d]: got v%0h src %0h expected v1 src %0h", k, dev2_o.a_valid, dev2_o.a_source, exp_src); end
            if (h2_o[0].a_ready) hs0++;
            if (h2_o[1].a_ready) hs1++;
            step();
        end
        h2_i[0].a_valid = 1'b0;
        h2_i[1].a_valid = 1'b0;
        d2(1'b1, 8'h80);
        step();
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (hs0 != 50 || hs1 != 50) begin n_fail++; $display("FAIL alt_balance: got %0d/%0d expected 50/50", hs0, hs1); end
        n_assert++; if (out2[0] !== 2'd0 || out2[1] !== 2'd0) begin n_fail++; $display("FAIL alt_drain: got %0d %0d expected 0 0", out2[0], out2[1]); end
    endtask

    task automatic test_lock();
        do_reset();
        h2_i[0] = mk_get(32'h400, 8'h01);
        step();
        h2_i[0].a_valid = 1'b0;
        d2(1'b1, 8'h01);
        step();
        d2(1'b0, 8'h00);
        h2_i[0] = mk_get(32'h404, 8'h02);
        dev2_i.a_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) h2_i[1] = mk_get(32'h500, 8'h03);
            #1;
            n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h02) begin n_fail++; $display("FAIL lock_hold[%0d]: got v%0h src %0h expected v1 src 2", c, dev2_o.a_valid, dev2_o.a_source); end
            step();
        end
        dev2_i.a_ready = 1'b1;
        #1;
        n_assert++; if (dev2_o.a_source !== 8'h02 || h2_o[0].a_ready !== 1'b1) begin n_fail++; $display("FAIL lock_release: got src %0h rdy %0h expected src 2 rdy 1", dev2_o.a_source, h2_o[0].a_ready); end
        step();
        #1;
        n_assert++; if (dev2_o.a_source !== 8'h83 || h2_o[1].a_ready !== 1'b1) begin n_fail++; $display("FAIL lock_next: got src %0h rdy %0h expected src 83 rdy 1", dev2_o.a_source, h2_o[1].a_ready); end
        step();
        h2_i[0].a_valid = 1'b0;
        h2_i[1].a_valid = 1'b0;
        #1;
        n_assert++; if (out2[0] !== 2'd1 || out2[1] !== 2'd1) begin n_fail++; $display("FAIL lock_counts: got %0d %0d expected 1 1", out2[0], out2[1]); end
        d2(1'b1, 8'h02);
        step();
        d2(1'b1, 8'h83);
        step();
        d2(1'b0, 8'h00);
    endtask

    task automatic test_max_outstanding();
        do_reset();
        h2_i[0] = mk_get(32'h600, 8'h00);
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h00) begin n_fail++; $display("FAIL max_first: got v%0h src %0h expected v1 src 0", dev2_o.a_valid, dev2_o.a_source); end
        step();
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h00) begin n_fail++; $display("FAIL max_second: got v%0h src %0h expected v1 src 0", dev2_o.a_valid, dev2_o.a_source); end
        step();
        #1;
        n_assert++; if (out2[0] !== 2'd2 || dev2_o.a_valid !== 1'b0 || h2_o[0].a_ready !== 1'b0) begin n_fail++; $display("FAIL max_block: got cnt %0d v%0h rdy %0h expected cnt 2 v0 rdy 0", out2[0], dev2_o.a_valid, h2_o[0].a_ready); end
        step();
        h2_i[1] = mk_get(32'h700, 8'h04);
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h84) begin n_fail++; $display("FAIL max_other_host: got v%0h src %0h expected v1 src 84", dev2_o.a_valid, dev2_o.a_source); end
        step();
        h2_i[1].a_valid = 1'b0;
        d2(1'b1, 8'h00);
        #1;
        n_assert++; if (h2_o[0].d_valid !== 1'b1 || dev2_o.a_valid !== 1'b0) begin n_fail++; $display("FAIL max_d_cycle: got dv %0h av %0h expected dv 1 av 0", h2_o[0].d_valid, dev2_o.a_valid); end
        step();
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (out2[0] !== 2'd1 || dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h00) begin n_fail++; $display("FAIL max_reeligible: got cnt %0d v%0h src %0h expected cnt 1 v1 src 0", out2[0], dev2_o.a_valid, dev2_o.a_source); end
        step();
        h2_i[0].a_valid = 1'b0;
        d2(1'b1, 8'h00); step();
        d2(1'b1, 8'h00); step();
        d2(1'b1, 8'h84); step();
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (out2[0] !== 2'd0 || out2[1] !== 2'd0) begin n_fail++; $display("FAIL max_drain: got %0d %0d expected 0 0", out2[0], out2[1]); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        h2_i[1] = mk_get(32'h800, 8'h01);
        step();
        d2(1'b1, 8'h81);
        #1;
        n_assert++; if (h2_o[1].d_valid !== 1'b1 || h2_o[1].a_ready !== 1'b1 || dev2_o.a_source !== 8'h81) begin n_fail++; $display("FAIL same_both: got dv %0h rdy %0h src %0h expected 1 1 81", h2_o[1].d_valid, h2_o[1].a_ready, dev2_o.a_source); end
        step();
        h2_i[1].a_valid = 1'b0;
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (out2[1] !== 2'd1 || out2[0] !== 2'd0) begin n_fail++; $display("FAIL same_count: got %0d %0d expected 0 1", out2[0], out2[1]); end
        d2(1'b1, 8'h81);
        step();
        d2(1'b0, 8'h00);
        #1;
        n_assert++; if (out2[1] !== 2'd0) begin n_fail++; $display("FAIL same_drain: got %0d expected 0", out2[1]); end
    endtask

    task automatic test_bad_tag();
        do_reset();
        h3_i[2] = mk_get(32'h900, 8'h01);
        #1;
        n_assert++; if (dev3_o.a_valid !== 1'b1 || dev3_o.a_source !== 8'h81) begin n_fail++; $display("FAIL bad_req_tag: got v%0h src %0h expected v1 src 81", dev3_o.a_valid, dev3_o.a_source); end
        step();
        h3_i[2].a_valid = 1'b0;
        for (int i = 0; i < 3; i++) h3_i[i].d_ready = 1'b0;
        dev3_i.d_valid = 1'b1; dev3_i.d_source = 8'hC5;
        #1;
        n_assert++; if (bad3 !== 1'b1 || dev3_o.d_ready !== 1'b1) begin n_fail++; $display("FAIL bad_sink: got bad %0h dready %0h expected 1 1", bad3, dev3_o.d_ready); end
        n_assert++; if ({h3_o[2].d_valid, h3_o[1].d_valid, h3_o[0].d_valid} !== 3'b000) begin n_fail++; $display("FAIL bad_no_route: got %0b%0b%0b expected 000", h3_o[2].d_valid, h3_o[1].d_valid, h3_o[0].d_valid); end
        step();
        dev3_i.d_valid = 1'b0;
        #1;
        n_assert++; if (bad3 !== 1'b0) begin n_fail++; $display("FAIL bad_pulse: got %0h expected 0", bad3); end
        n_assert++; if (out3[0] !== 2'd0 || out3[1] !== 2'd0 || out3[2] !== 2'd1) begin n_fail++; $display("FAIL bad_counts: got %0d %0d %0d expected 0 0 1", out3[0], out3[1], out3[2]); end
        dev3_i.d_valid = 1'b1; dev3_i.d_source = 8'h81;
        #1;
        n_assert++; if (h3_o[2].d_valid !== 1'b1 || h3_o[2].d_source !== 8'h01 || dev3_o.d_ready !== 1'b0 || bad3 !== 1'b0) begin n_fail++; $display("FAIL good_rsp_stall: got dv %0h src %0h dready %0h bad %0h expected 1 01 0 0", h3_o[2].d_valid, h3_o[2].d_source, dev3_o.d_ready, bad3); end
        step();
        #1;
        n_assert++; if (out3[2] !== 2'd1) begin n_fail++; $display("FAIL good_rsp_hold: got %0d expected 1", out3[2]); end
        h3_i[2].d_ready = 1'b1;
        #1;
        n_assert++; if (dev3_o.d_ready !== 1'b1) begin n_fail++; $display("FAIL good_rsp_ready: got %0h expected 1", dev3_o.d_ready); end
        step();
        dev3_i.d_valid = 1'b0;
        #1;
        n_assert++; if (out3[2] !== 2'd0) begin n_fail++; $display("FAIL good_rsp_drain: got %0d expected 0", out3[2]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        h2_i[0] = mk_get(32'hA00, 8'h00);
        step();
        dev2_i.a_ready = 1'b0;
        step();
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || out2[0] !== 2'd1) begin n_fail++; $display("FAIL mid_pre: got v%0h cnt %0d expected v1 cnt 1", dev2_o.a_valid, out2[0]); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b0 || h2_o[0].a_ready !== 1'b0 || out2[0] !== 2'd0) begin n_fail++; $display("FAIL mid_async: got v%0h rdy %0h cnt %0d expected 0 0 0", dev2_o.a_valid, h2_o[0].a_ready, out2[0]); end
        step();
        h2_i[0].a_valid = 1'b0;
        h2_i[1] = mk_get(32'hB00, 8'h02);
        dev2_i.a_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_assert++; if (dev2_o.a_valid !== 1'b1 || dev2_o.a_source !== 8'h82) begin n_fail++; $display("FAIL mid_unlocked: got v%0h src %0h expected v1 src 82", dev2_o.a_valid, dev2_o.a_source); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_max_outstanding();
        test_same_cycle();
        test_bad_tag();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
